// File: rtl/hex_seg_pkg.sv
// Shared definitions for the HEX display sequencer: active-low 7-segment
// patterns (bit0=a .. bit6=g) and the sequencer state encoding.
package hex_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern decoder.
module hex_seg_decoder
  import hex_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for one hex digit
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_display_sequencer.sv
// Avalon-MM master that refreshes a bank of HEX PIO slaves from a packed
// value, one digit per write, digit 0 first. Requests arriving during a
// refresh coalesce into a single pending refresh (last value wins).
module hex_display_sequencer
  import hex_seg_pkg::*;
#(
  parameter int          NUM_DIGITS  = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ADDR_STRIDE = 16,
  parameter int          ADDR_W      = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    update_req,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       avm_address,
  output logic                    avm_write,
  output logic [31:0]             avm_writedata,
  input  logic                    avm_waitrequest
);

  localparam int                IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(ADDR_STRIDE);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  seq_state_t                  state;
  logic [IDX_W-1:0]            idx;
  logic                        pending;
  logic [4*NUM_DIGITS-1:0]     snap_value;
  logic [NUM_DIGITS-1:0]       snap_blank;
  logic [4*NUM_DIGITS-1:0]     pend_value;
  logic [NUM_DIGITS-1:0]       pend_blank;

  logic [4*NUM_DIGITS-1:0]     src_value;
  logic [NUM_DIGITS-1:0]       src_blank;
  logic [IDX_W-1:0]            nxt_idx;
  logic [3:0]                  nxt_nibble;
  logic                        nxt_blank;
  logic [6:0]                  seg_pat;
  logic [6:0]                  nxt_pattern;
  logic [ADDR_W-1:0]           nxt_addr;
  logic                        accept;
  logic                        last;
  logic                        start_refresh;

  // The write in flight is accepted on an edge where the slave is not stalling
  assign accept = (state == WRITE) && !avm_waitrequest;
  assign last   = (idx == LAST_IDX);

  // A fresh refresh begins from IDLE on a request, or straight out of DONE
  // when a request is already waiting (or arrives in the DONE cycle itself)
  assign start_refresh = ((state == IDLE) && update_req) ||
                         ((state == DONE) && (update_req || pending));

  // Pick the snapshot and digit index that the next presented write uses
  always_comb begin
    src_value = snap_value;
    src_blank = snap_blank;
    nxt_idx   = idx + IDX_W'(1);
    case (state)
      IDLE: begin
        src_value = value;
        src_blank = blank_mask;
        nxt_idx   = '0;
      end
      DONE: begin
        nxt_idx = '0;
        if (update_req) begin
          src_value = value;
          src_blank = blank_mask;
        end else begin
          src_value = pend_value;
          src_blank = pend_blank;
        end
      end
      default: ;
    endcase
  end

  // Extract the nibble and blank bit of the selected digit
  always_comb begin
    nxt_nibble = src_value[3:0];
    nxt_blank  = src_blank[0];
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (nxt_idx == IDX_W'(i)) begin
        nxt_nibble = src_value[4*i +: 4];
        nxt_blank  = src_blank[i];
      end
    end
  end

  hex_seg_decoder u_decoder (
    .nibble (nxt_nibble),
    .seg    (seg_pat)
  );

  assign nxt_pattern = nxt_blank ? SEG_BLANK : seg_pat;
  assign nxt_addr    = BASE + (ADDR_W'(nxt_idx) * STRIDE);

  // Sequencer FSM: registered bus outputs, digit index and pending flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      idx           <= '0;
      pending       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= BASE;
      avm_writedata <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (update_req) begin
            state         <= WRITE;
            idx           <= nxt_idx;
            busy          <= 1'b1;
            avm_write     <= 1'b1;
            avm_address   <= nxt_addr;
            avm_writedata <= {25'b0, nxt_pattern};
          end
        end
        WRITE: begin
          if (update_req) begin
            pending <= 1'b1;
          end
          if (accept) begin
            if (!last) begin
              idx           <= nxt_idx;
              avm_address   <= nxt_addr;
              avm_writedata <= {25'b0, nxt_pattern};
            end else begin
              state     <= DONE;
              avm_write <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        DONE: begin
          done    <= 1'b0;
          pending <= 1'b0;
          if (start_refresh) begin
            state         <= WRITE;
            idx           <= nxt_idx;
            avm_write     <= 1'b1;
            avm_address   <= nxt_addr;
            avm_writedata <= {25'b0, nxt_pattern};
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          avm_write <= 1'b0;
        end
      endcase
    end
  end

  // Active and pending snapshots: the active one only changes when a refresh
  // starts, the pending one takes every request made while busy
  always_ff @(posedge clk) begin
    if (start_refresh) begin
      snap_value <= src_value;
      snap_blank <= src_blank;
    end
    if (update_req && (state != IDLE)) begin
      pend_value <= value;
      pend_blank <= blank_mask;
    end
  end

endmodule
